vga_mode_ctrl: RTL

Mode-switch sequencer for the low-level VGA timing core. It accepts new horizontal and vertical timing sets through a valid/ready handshake and validates them. It applies each new set only at a frame boundary, then holds the timing core in reset long enough for its internal reset pipeline to clear before releasing it. It sits between the register/bus side and the timing core, and drives the core's mode inputs and reset.

---
 rtl/vga_mode_pkg.sv | 23 ++
 rtl/vga_mode_check.sv | 14 +
 rtl/vga_mode_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/vga_mode_pkg.sv
// Shared types and constants for the VGA mode-switch sequencer.
package vga_mode_pkg;

    // Field width used by the ordering checker; timing fields up to 16 bits are supported.
    localparam int MODE_FW = 16;

    localparam logic [MODE_FW-1:0] MIN_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RUN        = 2'd1,
        ST_WAIT_FRAME = 2'd2,
        ST_HOLD       = 2'd3
    } state_e;

    typedef struct packed {
        logic [MODE_FW-1:0] width;
        logic [MODE_FW-1:0] porch;
        logic [MODE_FW-1:0] synch;
        logic [MODE_FW-1:0] raw;
    } mode_t;

endpackage

// File: rtl/vga_mode_check.sv
// Combinational ordering check for one timing axis: MIN_WIDTH < width < porch < synch < raw.
module vga_mode_check
    import vga_mode_pkg::*;
(
    input  mode_t mode,
    output logic  ok
);

    assign ok = (mode.width > MIN_WIDTH) &&
                (mode.porch > mode.width) &&
                (mode.synch > mode.porch) &&
                (mode.raw   > mode.synch);

endmodule

// File: rtl/vga_mode_ctrl.sv
// Mode-switch sequencer: latches requested timing, applies it on a frame boundary, resets the core.
// Define VGA_MODE_CHECK_EN to reject requests whose timing fields are not strictly ordered.
module vga_mode_ctrl
    import vga_mode_pkg::*;
#(
    parameter int HW          = 12,
    parameter int VW          = 12,
    parameter int HOLD_CYCLES = 4,
    parameter int TW          = 24
) (
    input  logic          i_pixclk,
    input  logic          i_reset_n,
    input  logic          i_mode_valid,
    output logic          o_mode_ready,
    input  logic [HW-1:0] i_hm_width,
    input  logic [HW-1:0] i_hm_porch,
    input  logic [HW-1:0] i_hm_synch,
    input  logic [HW-1:0] i_hm_raw,
    input  logic [VW-1:0] i_vm_height,
    input  logic [VW-1:0] i_vm_porch,
    input  logic [VW-1:0] i_vm_synch,
    input  logic [VW-1:0] i_vm_raw,
    input  logic          i_newframe,
    output logic [HW-1:0] o_hm_width,
    output logic [HW-1:0] o_hm_porch,
    output logic [HW-1:0] o_hm_synch,
    output logic [HW-1:0] o_hm_raw,
    output logic [VW-1:0] o_vm_height,
    output logic [VW-1:0] o_vm_porch,
    output logic [VW-1:0] o_vm_synch,
    output logic [VW-1:0] o_vm_raw,
    output logic          o_vga_reset,
    output logic          o_mode_err,
    output logic          o_timeout,
    output logic          o_active
);

    localparam logic [1:0] S_IDLE       = ST_IDLE;
    localparam logic [1:0] S_RUN        = ST_RUN;
    localparam logic [1:0] S_WAIT_FRAME = ST_WAIT_FRAME;
    localparam logic [1:0] S_HOLD       = ST_HOLD;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    typedef struct packed {
        logic [HW-1:0] width;
        logic [HW-1:0] porch;
        logic [HW-1:0] synch;
        logic [HW-1:0] raw;
    } h_set_t;

    typedef struct packed {
        logic [VW-1:0] height;
        logic [VW-1:0] porch;
        logic [VW-1:0] synch;
        logic [VW-1:0] raw;
    } v_set_t;

    logic [1:0]    state_q, state_d;
    logic [7:0]    hold_q;
    logic [TW-1:0] wd_q;
    h_set_t        req_h, shadow_h, applied_h;
    v_set_t        req_v, shadow_v, applied_v;
    logic          accept, req_ok;
    logic          load_shadow, apply_req, apply_shadow;
    logic          err_d, timeout_d;

    assign req_h  = '{i_hm_width, i_hm_porch, i_hm_synch, i_hm_raw};
    assign req_v  = '{i_vm_height, i_vm_porch, i_vm_synch, i_vm_raw};
    assign accept = i_mode_valid && o_mode_ready;

`ifdef VGA_MODE_CHECK_EN
    mode_t chk_h, chk_v;
    logic  h_ok, v_ok;

    assign chk_h = '{MODE_FW'(i_hm_width),  MODE_FW'(i_hm_porch), MODE_FW'(i_hm_synch), MODE_FW'(i_hm_raw)};
    assign chk_v = '{MODE_FW'(i_vm_height), MODE_FW'(i_vm_porch), MODE_FW'(i_vm_synch), MODE_FW'(i_vm_raw)};

    vga_mode_check u_check_h (.mode(chk_h), .ok(h_ok));
    vga_mode_check u_check_v (.mode(chk_v), .ok(v_ok));

    assign req_ok = h_ok && v_ok;
`else
    assign req_ok = 1'b1;
`endif

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        load_shadow  = 1'b0;
        apply_req    = 1'b0;
        apply_shadow = 1'b0;
        err_d        = 1'b0;
        timeout_d    = 1'b0;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (accept) begin
                    if (req_ok) begin
                        load_shadow = 1'b1;
                        apply_req   = (state_q == S_IDLE);
                        state_d     = (state_q == S_IDLE) ? S_HOLD : S_WAIT_FRAME;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WAIT_FRAME: begin
                // A frame boundary wins over a simultaneous watchdog expiry.
                if (i_newframe) begin
                    apply_shadow = 1'b1;
                    state_d      = S_HOLD;
                end else if (wd_q == '1) begin
                    apply_shadow = 1'b1;
                    timeout_d    = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_q == '0) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            wd_q       <= '0;
            o_mode_err <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            state_q    <= state_d;
            o_mode_err <= err_d;
            o_timeout  <= timeout_d;
            wd_q       <= (state_q == S_WAIT_FRAME) ? wd_q + 1'b1 : '0;
            if (state_d == S_HOLD && state_q != S_HOLD)
                hold_q <= HOLD_LOAD;
            else if (state_q == S_HOLD)
                hold_q <= hold_q - 1'b1;
        end
    end

    // NOTE: the shadow set is reset too, so a reset reliably discards any pending request.
    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            shadow_h  <= '0;
            shadow_v  <= '0;
            applied_h <= '0;
            applied_v <= '0;
        end else begin
            if (load_shadow) begin
                shadow_h <= req_h;
                shadow_v <= req_v;
            end
            if (apply_req) begin
                applied_h <= req_h;
                applied_v <= req_v;
            end else if (apply_shadow) begin
                applied_h <= shadow_h;
                applied_v <= shadow_v;
            end
        end
    end

    assign o_mode_ready = (state_q == S_IDLE) || (state_q == S_RUN);
    assign o_active     = (state_q == S_RUN);
    assign o_vga_reset  = (state_q == S_IDLE) || (state_q == S_HOLD);

    assign o_hm_width  = applied_h.width;
    assign o_hm_porch  = applied_h.porch;
    assign o_hm_synch  = applied_h.synch;
    assign o_hm_raw    = applied_h.raw;
    assign o_vm_height = applied_v.height;
    assign o_vm_porch  = applied_v.porch;
    assign o_vm_synch  = applied_v.synch;
    assign o_vm_raw    = applied_v.raw;

endmodule
